// File: rtl/bp_fe_cmd_scheduler.sv
// Merges redirect-class and attaboy FE commands onto the single FE command port.
// Redirects use a one-entry skid. Attaboys use a droppable FIFO. The two sources are arbitrated with an anti-starvation override.
module bp_fe_cmd_scheduler #(
  parameter int fe_cmd_width_lp  = 64,  // bp_fe_cmd_s width; opcode occupies the low bits
  parameter int attaboy_els_p    = 4,
  parameter int starve_limit_p   = 8,
  parameter int drop_cnt_width_p = 8
) (
  input  logic                               clk_i,
  input  logic                               reset_n_i,
  input  logic [fe_cmd_width_lp-1:0]         redir_cmd_i,
  input  logic                               redir_v_i,
  output logic                               redir_ready_o,
  input  logic [fe_cmd_width_lp-1:0]         attaboy_cmd_i,
  input  logic                               attaboy_v_i,
  output logic                               attaboy_ready_o,
  output logic [fe_cmd_width_lp-1:0]         fe_cmd_o,
  output logic                               fe_cmd_v_o,
  input  logic                               fe_cmd_yumi_i,
  output logic [$clog2(attaboy_els_p+1)-1:0] attaboy_cnt_o,
  output logic [drop_cnt_width_p-1:0]        attaboy_drop_cnt_o
);

  localparam int ptr_w    = $clog2(attaboy_els_p);
  localparam int cnt_w    = $clog2(attaboy_els_p + 1);
  localparam int starve_w = $clog2(starve_limit_p + 1);
  localparam int sum_w    = ((drop_cnt_width_p > cnt_w) ? drop_cnt_width_p : cnt_w) + 2;
  localparam logic [2:0] e_op_state_reset = 3'd0;

  typedef enum logic {e_boot, e_run} state_e;
  state_e state, state_n;
  logic   boot;

  logic                        skid_v;
  logic [fe_cmd_width_lp-1:0]  skid_cmd;
  logic [fe_cmd_width_lp-1:0]  mem [attaboy_els_p];
  logic [ptr_w-1:0]            rd_ptr, wr_ptr;
  logic [cnt_w-1:0]            cnt;
  logic                        lock, sel_q, sel, sel_arb;  // sel: 1 = FIFO head, 0 = skid
  logic [starve_w-1:0]         starve_cnt;
  logic [drop_cnt_width_p-1:0] drop_cnt, drop_cnt_n;
  logic [cnt_w:0]              drop_inc;
  logic [sum_w-1:0]            drop_sum;
  logic                        fifo_empty, fifo_full, yumi_skid, yumi_fifo, flush, enq;

  assign fifo_empty = (cnt == '0);
  assign fifo_full  = (cnt == cnt_w'(attaboy_els_p));

  assign sel_arb    = ~(skid_v & ((starve_cnt < starve_w'(starve_limit_p)) | fifo_empty));
  assign sel        = lock ? sel_q : sel_arb;
  assign fe_cmd_v_o = sel ? ~fifo_empty : skid_v;
  assign fe_cmd_o   = fe_cmd_v_o ? (sel ? mem[rd_ptr] : skid_cmd) : '0;

  assign yumi_skid = fe_cmd_yumi_i & ~sel;
  assign yumi_fifo = fe_cmd_yumi_i & sel;
  assign flush     = yumi_skid & (skid_cmd[2:0] == e_op_state_reset);
  assign enq       = attaboy_v_i & ~boot & ~flush & (~fifo_full | yumi_fifo);

  assign redir_ready_o      = reset_n_i & (~skid_v | yumi_skid);
  assign attaboy_ready_o    = reset_n_i;
  assign attaboy_cnt_o      = cnt;
  assign attaboy_drop_cnt_o = drop_cnt;

  // A flush discards every resident entry plus any attaboy arriving in the same cycle.
  always_comb begin
    drop_inc = '0;
    if (boot)
      drop_inc = (cnt_w+1)'(attaboy_v_i);
    else if (flush)
      drop_inc = (cnt_w+1)'(cnt) + (cnt_w+1)'(attaboy_v_i);
    else if (attaboy_v_i & fifo_full & ~yumi_fifo)
      drop_inc = (cnt_w+1)'(1);
    drop_sum   = sum_w'(drop_cnt) + sum_w'(drop_inc);
    drop_cnt_n = (drop_sum > sum_w'({drop_cnt_width_p{1'b1}})) ? '1 : drop_cnt_width_p'(drop_sum);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state <= e_boot;
    else            state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (state == e_boot && fe_cmd_yumi_i && fe_cmd_o[2:0] == e_op_state_reset)
      state_n = e_run;
  end

  always_comb begin
    boot = (state == e_boot);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      skid_v     <= 1'b0;
      skid_cmd   <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      cnt        <= '0;
      lock       <= 1'b0;
      sel_q      <= 1'b0;
      starve_cnt <= '0;
      drop_cnt   <= '0;
    end else begin
      if (redir_v_i & redir_ready_o) begin
        skid_v   <= 1'b1;
        skid_cmd <= redir_cmd_i;
      end else if (yumi_skid) begin
        skid_v   <= 1'b0;
      end
      if (enq) wr_ptr <= wr_ptr + ptr_w'(1);
      if (flush)          rd_ptr <= wr_ptr;
      else if (yumi_fifo) rd_ptr <= rd_ptr + ptr_w'(1);
      if (flush) cnt <= '0;
      else       cnt <= cnt + cnt_w'(enq) - cnt_w'(yumi_fifo);
      lock  <= fe_cmd_v_o & ~fe_cmd_yumi_i;
      sel_q <= sel;
      if (flush | yumi_fifo | fifo_empty)
        starve_cnt <= '0;
      else if (starve_cnt < starve_w'(starve_limit_p))
        starve_cnt <= starve_cnt + starve_w'(1);
      drop_cnt <= drop_cnt_n;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) mem[wr_ptr] <= attaboy_cmd_i;
  end

`ifndef SYNTHESIS
  assert property (@(posedge clk_i) disable iff (!reset_n_i) fe_cmd_yumi_i |-> fe_cmd_v_o)
    else $error("fe_cmd_yumi_i asserted without fe_cmd_v_o");
`endif

endmodule

// File: tb/tb_bp_fe_cmd_scheduler.sv
// Directed bench for bp_fe_cmd_scheduler: expected issue order is queued as commands are driven.
// The queue is popped and compared on each yumi.
module tb_bp_fe_cmd_scheduler;
  localparam int W = 32;
  localparam logic [2:0] OP_SR = 3'd0;
  localparam logic [2:0] OP_PC = 3'd1;
  localparam logic [2:0] OP_AB = 3'd2;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [W-1:0] redir_cmd, attaboy_cmd, fe_cmd;
  logic         redir_v, redir_ready, attaboy_v, attaboy_ready, fe_cmd_v, yumi;
  logic [2:0]   attaboy_cnt;
  logic [7:0]   drop_cnt;

  int           checks = 0;
  int           errors = 0;
  int           exp_drop = 0;
  logic [W-1:0] exp_q [$];

  bp_fe_cmd_scheduler #(
    .fe_cmd_width_lp(W), .attaboy_els_p(4), .starve_limit_p(8), .drop_cnt_width_p(8)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .redir_cmd_i(redir_cmd), .redir_v_i(redir_v), .redir_ready_o(redir_ready),
    .attaboy_cmd_i(attaboy_cmd), .attaboy_v_i(attaboy_v), .attaboy_ready_o(attaboy_ready),
    .fe_cmd_o(fe_cmd), .fe_cmd_v_o(fe_cmd_v), .fe_cmd_yumi_i(yumi),
    .attaboy_cnt_o(attaboy_cnt), .attaboy_drop_cnt_o(drop_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [W-1:0] mk(input logic [2:0] op, input int id);
    return {id[28:0], op};
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Consume the presented command this cycle and compare it with the scoreboard head.
  task automatic take(input string tag);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed an issue slot, expected none queued", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_v"}, W'(fe_cmd_v), W'(1));
      chk(tag, fe_cmd, e);
    end
    yumi = 1'b1;
    step();
    yumi = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; redir_cmd = '0; redir_v = 1'b0; attaboy_cmd = '0; attaboy_v = 1'b0; yumi = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_v",       W'(fe_cmd_v),      W'(0));
    chk("rst_rready",  W'(redir_ready),   W'(0));
    chk("rst_aready",  W'(attaboy_ready), W'(0));
    chk("rst_cnt",     W'(attaboy_cnt),   W'(0));
    chk("rst_drop",    W'(drop_cnt),      W'(0));
    chk("rst_cmd",     fe_cmd,            W'(0));
    reset_n = 1'b1;
    #1;
    chk("rel_rready", W'(redir_ready),   W'(1));
    chk("rel_aready", W'(attaboy_ready), W'(1));

    // boot: state_reset redirect plus an attaboy that must be dropped
    redir_cmd = mk(OP_SR, 1); redir_v = 1'b1;
    attaboy_cmd = mk(OP_AB, 100); attaboy_v = 1'b1;
    exp_q.push_back(mk(OP_SR, 1));
    #1 chk("boot_lat_v", W'(fe_cmd_v), W'(0));
    step();
    redir_v = 1'b0; attaboy_v = 1'b0; exp_drop = 1;
    chk("boot_drop", W'(drop_cnt),    W'(exp_drop));
    chk("boot_cnt",  W'(attaboy_cnt), W'(0));
    take("boot_sr");
    chk("post_sr_v", W'(fe_cmd_v), W'(0));
    attaboy_cmd = mk(OP_AB, 101); attaboy_v = 1'b1; exp_q.push_back(mk(OP_AB, 101));
    step();
    attaboy_v = 1'b0;
    chk("run_cnt",  W'(attaboy_cnt), W'(1));
    chk("run_drop", W'(drop_cnt),    W'(exp_drop));
    take("run_ab");
    chk("run_cnt0", W'(attaboy_cnt), W'(0));

    // fill the FIFO, overflow once, then enqueue while the head is dequeued
    for (int i = 0; i < 4; i++) begin
      attaboy_cmd = mk(OP_AB, 110 + i); attaboy_v = 1'b1; exp_q.push_back(mk(OP_AB, 110 + i));
      step();
    end
    chk("full_cnt",  W'(attaboy_cnt), W'(4));
    chk("full_drop", W'(drop_cnt),    W'(exp_drop));
    attaboy_cmd = mk(OP_AB, 114);
    step();
    attaboy_v = 1'b0; exp_drop++;
    chk("ovf_cnt",  W'(attaboy_cnt), W'(4));
    chk("ovf_drop", W'(drop_cnt),    W'(exp_drop));
    attaboy_cmd = mk(OP_AB, 115); attaboy_v = 1'b1; exp_q.push_back(mk(OP_AB, 115));
    take("full_deq_head");
    attaboy_v = 1'b0;
    chk("full_deq_cnt",  W'(attaboy_cnt), W'(4));
    chk("full_deq_drop", W'(drop_cnt),    W'(exp_drop));
    for (int i = 0; i < 4; i++) take($sformatf("drain%0d", i));
    chk("drain_cnt", W'(attaboy_cnt), W'(0));
    chk("drain_v",   W'(fe_cmd_v),    W'(0));

    // anti-starvation: 8 redirect wins, then the attaboy is forced
    redir_cmd = mk(OP_PC, 200); redir_v = 1'b1;
    attaboy_cmd = mk(OP_AB, 120); attaboy_v = 1'b1;
    exp_q.push_back(mk(OP_PC, 200));
    step();
    attaboy_v = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      redir_cmd = mk(OP_PC, 200 + k);
      if (k == 8) exp_q.push_back(mk(OP_AB, 120));
      exp_q.push_back(mk(OP_PC, 200 + k));
      take($sformatf("starve_win%0d", k));
    end
    redir_v = 1'b0;
    #1 chk("starve_rready", W'(redir_ready), W'(0));
    take("starve_forced_ab");
    chk("starve_clr", W'(dut.starve_cnt), W'(0));
    chk("starve_cnt", W'(attaboy_cnt),    W'(0));
    take("starve_redir_after");
    chk("starve_idle_v", W'(fe_cmd_v), W'(0));

    // lock: stalled attaboy must not be swapped for a late redirect
    attaboy_cmd = mk(OP_AB, 130); attaboy_v = 1'b1; exp_q.push_back(mk(OP_AB, 130));
    step();
    attaboy_v = 1'b0;
    redir_cmd = mk(OP_PC, 140); redir_v = 1'b1; exp_q.push_back(mk(OP_PC, 140));
    #1 chk("lock_c1", fe_cmd, mk(OP_AB, 130));
    step();
    redir_v = 1'b0;
    chk("lock_c2", fe_cmd, mk(OP_AB, 130));
    chk("lock_c2_rready", W'(redir_ready), W'(0));
    step();
    chk("lock_c3", fe_cmd, mk(OP_AB, 130));
    step();
    take("lock_release");
    take("lock_redir");
    chk("lock_idle_v", W'(fe_cmd_v), W'(0));

    // state_reset flush of three queued attaboys
    redir_cmd = mk(OP_SR, 150); redir_v = 1'b1;
    attaboy_cmd = mk(OP_AB, 151); attaboy_v = 1'b1;
    exp_q.push_back(mk(OP_SR, 150));
    step();
    redir_v = 1'b0;
    attaboy_cmd = mk(OP_AB, 152);
    step();
    attaboy_cmd = mk(OP_AB, 153);
    step();
    attaboy_v = 1'b0;
    chk("flush_pre_cnt", W'(attaboy_cnt), W'(3));
    take("flush_sr");
    exp_drop += 3;
    chk("flush_cnt",  W'(attaboy_cnt), W'(0));
    chk("flush_drop", W'(drop_cnt),    W'(exp_drop));
    chk("flush_v",    W'(fe_cmd_v),    W'(0));

    // asynchronous reset in the middle of a stall
    attaboy_cmd = mk(OP_AB, 160); attaboy_v = 1'b1;
    step();
    attaboy_v = 1'b0;
    step();
    chk("stall_v", W'(fe_cmd_v), W'(1));
    #2 reset_n = 1'b0;
    #1;
    chk("async_v",      W'(fe_cmd_v),      W'(0));
    chk("async_cnt",    W'(attaboy_cnt),   W'(0));
    chk("async_drop",   W'(drop_cnt),      W'(0));
    chk("async_cmd",    fe_cmd,            W'(0));
    chk("async_rready", W'(redir_ready),   W'(0));
    chk("async_aready", W'(attaboy_ready), W'(0));
    #1 reset_n = 1'b1;
    step();
    attaboy_cmd = mk(OP_AB, 161); attaboy_v = 1'b1;
    step();
    attaboy_v = 1'b0;
    chk("reboot_drop", W'(drop_cnt),    W'(1));
    chk("reboot_cnt",  W'(attaboy_cnt), W'(0));

    chk("sb_empty", W'(exp_q.size()), W'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bp_fe_cmd_scheduler.md
Name: bp_fe_cmd_scheduler

Overview:
Schedules FE commands from two BE sources onto the single FE command port consumed by the FE controller. Redirect-class commands (state reset, pc redirection, fills, fences, wait) go through a one-entry skid register. Attaboy branch-training commands go through a small droppable FIFO. The block arbitrates between the two with redirect priority and an anti-starvation override, holds its selection stable until the controller takes it, and flushes stale training on state reset.

Parameters:
bp_params_p, e_bp_default_cfg, processor configuration; supplies fe_cmd_width_lp.
attaboy_els_p, 4, attaboy FIFO depth (power of 2, >=2).
starve_limit_p, 8, consecutive cycles a non-empty attaboy FIFO may lose arbitration before it is forced.
drop_cnt_width_p, 8, width of the saturating drop counter.

Ports:
clk_i  in  1  clock, rising edge
reset_n_i  in  1  reset, asynchronous, active-low
redir_cmd_i  in  fe_cmd_width_lp  redirect-class bp_fe_cmd_s from BE
redir_v_i  in  1  redirect valid
redir_ready_o  out  1  skid can accept (ready-and)
attaboy_cmd_i  in  fe_cmd_width_lp  attaboy bp_fe_cmd_s from BE
attaboy_v_i  in  1  attaboy valid
attaboy_ready_o  out  1  always 1 outside reset; full-FIFO enqueues are dropped, not stalled
fe_cmd_o  out  fe_cmd_width_lp  command to FE controller
fe_cmd_v_o  out  1  command valid
fe_cmd_yumi_i  in  1  controller consumed fe_cmd_o
attaboy_cnt_o  out  $clog2(attaboy_els_p+1)  FIFO occupancy
attaboy_drop_cnt_o  out  drop_cnt_width_p  saturating count of dropped attaboys

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous, active-low, on reset_n_i.
- While reset_n_i=0 (asserted at any time, including mid-transfer): skid empty, FIFO empty, lock clear, starve counter 0, drop counter 0, state e_boot.
  - Outputs under reset: fe_cmd_v_o=0, redir_ready_o=0, attaboy_ready_o=0, attaboy_cnt_o=0, attaboy_drop_cnt_o=0, fe_cmd_o=0.
  - The first clock edge after deassertion behaves normally.
- State machine, two states:
  - e_boot: attaboys are accepted and dropped (drop counter +1 each). Redirects are accepted into the skid and forwarded. Transition to e_run on the cycle a command with opcode e_op_state_reset is yumi'd.
  - e_run: normal operation. There is no return to e_boot except by reset.
- Redirect skid:
  - redir_ready_o = ~skid_v | (sel==skid & fe_cmd_yumi_i). Enqueue on the same cycle as dequeue is permitted.
  - Latency: accepted at cycle N, earliest fe_cmd_v_o at N+1.
- Attaboy FIFO:
  - Enqueue when attaboy_v_i in e_run.
  - If full and no dequeue in the same cycle: drop, drop counter +1, saturating at all-ones.
  - Full with a dequeue in the same cycle: accepted, not dropped.
  - Latency: 1 cycle. Order: FIFO order preserved; pointers wrap modulo attaboy_els_p.
- Arbitration, evaluated only when the lock is clear:
  - Select the skid if skid_v and (starve_cnt < starve_limit_p or FIFO empty).
  - Otherwise select the FIFO head if the FIFO is non-empty.
  - fe_cmd_v_o = selected source valid.
- Lock:
  - Set when fe_cmd_v_o=1 and fe_cmd_yumi_i=0; cleared on yumi.
  - While locked, sel and fe_cmd_o must not change (no retraction, no swap), even if a redirect arrives.
- Starve counter:
  - Increments each cycle the FIFO is non-empty and no attaboy is yumi'd, saturating at starve_limit_p.
  - Clears on attaboy yumi or FIFO empty.
- State-reset flush: when an e_op_state_reset command is yumi'd from the skid:
  - All FIFO entries present at the next edge are discarded and counted as drops.
  - A same-cycle attaboy enqueue is also dropped.
  - Starve counter clears.
  - If the FIFO head is locked, the flush cannot happen, because the skid is not selected.
- fe_cmd_yumi_i while fe_cmd_v_o=0 is illegal (assertion).

Test Plan:
- Reset, then redir_v_i=1 with state_reset opcode at cycle 1 -> fe_cmd_v_o=1 at cycle 2; yumi at cycle 2 -> state e_run at cycle 3; attaboy sent in cycle 1 -> attaboy_drop_cnt_o=1.
- e_run: 4 attaboys on consecutive cycles, no yumi, then a 5th -> attaboy_cnt_o=4, drop count +1; 5th sent on a cycle with yumi of the head -> no drop, cnt stays 4.
- FIFO holds 1 attaboy; redirect stream continuously valid with yumi every cycle -> after 8 redirect wins, cycle 9 selects the attaboy; starve counter returns to 0.
- Attaboy presented, yumi withheld 3 cycles, redirect arrives in cycle 1 of the stall -> fe_cmd_o unchanged all 3 cycles; redirect issued the cycle after yumi.
- 3 attaboys queued, state_reset redirect yumi'd -> attaboy_cnt_o=0 next cycle, drop count +3.
- reset_n_i pulsed low mid-stall (fe_cmd_v_o=1) without a clock edge -> fe_cmd_v_o, attaboy_cnt_o and drop count at 0 immediately; state e_boot.
